// File: rtl/pc_branch_sequencer.sv
// Multi-cycle fetch-path PC sequencer: FETCH handshake, EXEC branch wait, PC update.
// Define PC_BR_WRAP_FAULT_EN to turn out-of-range taken-branch targets into a sticky fault.
module pc_branch_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt_req,
  output logic            fetch_valid,
  output logic [PC_W-1:0] fetch_addr,
  input  logic            fetch_ready,
  input  logic            resp_valid,
  input  logic            br_taken,
  input  logic [3:0]      br_off,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic [15:0]     instr_count,
  output logic            fault
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [15:0]     count_nxt;
  logic            halt_pending, halt_nxt;

  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_target;

  assign off_ext = PC_W'($signed({br_off, 2'b00}));
  assign seq_pc  = pc + PC_W'(4);

`ifdef PC_BR_WRAP_FAULT_EN
  // Two extra bits hold the true signed sum so an out-of-range target is visible.
  logic [PC_W+1:0] br_sum_ext;
  logic            br_wrap;
  logic            fault_q, fault_nxt;

  assign br_sum_ext = {2'b00, pc} + (PC_W+2)'(4) + {{2{off_ext[PC_W-1]}}, off_ext};
  assign br_target  = br_sum_ext[PC_W-1:0];
  assign br_wrap    = |br_sum_ext[PC_W+1:PC_W];
  assign fault      = fault_q;
`else
  assign br_target  = seq_pc + off_ext;
  assign fault      = 1'b0;
`endif

  assign fetch_valid = (state == FETCH);
  assign fetch_addr  = pc;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = instr_count;
    halt_nxt  = halt_pending;
`ifdef PC_BR_WRAP_FAULT_EN
    fault_nxt = fault_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          halt_nxt  = 1'b0;
`ifdef PC_BR_WRAP_FAULT_EN
          fault_nxt = 1'b0;
`endif
        end
      end
      FETCH: begin
        if (halt_req) halt_nxt = 1'b1;
        if (fetch_ready) state_nxt = EXEC;
      end
      EXEC: begin
        if (halt_req) halt_nxt = 1'b1;
        if (resp_valid) begin
`ifdef PC_BR_WRAP_FAULT_EN
          if (br_taken && br_wrap) begin
            fault_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
`else
          begin
`endif
            pc_nxt    = br_taken ? br_target : seq_pc;
            count_nxt = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;
            state_nxt = (halt_pending || halt_req) ? IDLE : FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr_count  <= '0;
      halt_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      instr_count  <= count_nxt;
      halt_pending <= halt_nxt;
    end
  end

`ifdef PC_BR_WRAP_FAULT_EN
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_nxt;
  end
`endif

endmodule
